phys_free_list: RTL

PHYS_FREE_LIST -- requirements
Module: phys_free_list

---
 rtl/phys_free_list.sv | 112 +++++++++++
 1 files changed

// File: rtl/phys_free_list.sv
// Physical register free list: circular buffer of free pregs with checkpoint recovery.
// Define FL_DOUBLE_FREE_CHECK_EN to compile in the in-list bitmap that rejects double frees.
package buffer_pkgs;
   localparam int unsigned PREGS  = 64;
   localparam int unsigned PREG_W = 6;
endpackage

module phys_free_list #(
   parameter int unsigned PREGS  = buffer_pkgs::PREGS,
   parameter int unsigned PREG_W = buffer_pkgs::PREG_W,
   parameter int unsigned AREG   = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    alloc_req_i,
   output logic                    alloc_gnt_o,
   output logic [PREG_W-1:0]       alloc_preg_o,
   input  logic                    free_valid_i,
   input  logic [PREG_W-1:0]       free_preg_i,
   output logic [PREG_W-1:0]       chkpt_head_o,
   output logic [PREG_W-1:0]       chkpt_tail_o,
   output logic [$clog2(PREGS):0]  chkpt_free_count_o,
   input  logic                    fl_recover_i,
   input  logic [PREG_W-1:0]       fl_recover_head_i,
   input  logic [PREG_W-1:0]       fl_recover_tail_i,
   input  logic [$clog2(PREGS):0]  fl_recover_free_count_i,
   output logic                    empty_o,
   output logic                    error_o
);
   localparam int unsigned CW = $clog2(PREGS) + 1;

   logic [PREG_W-1:0] buf_q [PREGS];
   logic [PREG_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic              error_q, error_d;
   logic              grant, dup, free_ok;

   // Checkpointed tail and count are redundant: the live tail is authoritative.
   logic unused_recover;
   assign unused_recover = ^{fl_recover_tail_i, fl_recover_free_count_i};

   assign grant   = alloc_req_i && (count_q != '0) && !fl_recover_i;
   assign free_ok = free_valid_i && (fl_recover_i || (count_q != CW'(PREGS))) && !dup;

`ifdef FL_DOUBLE_FREE_CHECK_EN
   logic [PREGS-1:0]  map_q, map_d, rec_map;
   logic [PREG_W-1:0] rec_len;

   // Rebuild the in-list set from the slots between the recovered head and the live tail.
   always_comb begin
      rec_map = '0;
      rec_len = PREG_W'(tail_q - fl_recover_head_i);
      for (int j = 0; j < int'(PREGS); j++) begin
         if (PREG_W'(PREG_W'(j) - fl_recover_head_i) < rec_len) rec_map[buf_q[j]] = 1'b1;
      end
   end

   // A preg leaving via this cycle's grant may legitimately come back in the same cycle.
   assign dup = fl_recover_i ? rec_map[free_preg_i]
                             : (map_q[free_preg_i] && !(grant && (buf_q[head_q] == free_preg_i)));

   always_comb begin
      map_d = fl_recover_i ? rec_map : map_q;
      if (grant)   map_d[buf_q[head_q]] = 1'b0;
      if (free_ok) map_d[free_preg_i]   = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(PREGS); i++) map_q[i] <= (i >= int'(AREG));
      end else begin
         map_q <= map_d;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // Next head/tail/count; recovery rewinds head and recomputes count against the live tail.
   always_comb begin
      head_d  = fl_recover_i ? fl_recover_head_i : head_q + PREG_W'(grant);
      tail_d  = tail_q + PREG_W'(free_ok);
      count_d = count_q + CW'(free_ok) - CW'(grant);
      if (fl_recover_i) count_d = CW'(PREG_W'(tail_d - fl_recover_head_i));
      error_d = error_q || (free_valid_i && !free_ok);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(PREGS); i++)
            buf_q[i] <= (i < int'(PREGS - AREG)) ? PREG_W'(AREG + i) : '0;
         head_q  <= '0;
         tail_q  <= PREG_W'(PREGS - AREG);
         count_q <= CW'(PREGS - AREG);
         error_q <= 1'b0;
      end else begin
         if (free_ok) buf_q[tail_q] <= free_preg_i;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         error_q <= error_d;
      end
   end

   assign alloc_gnt_o        = grant;
   assign alloc_preg_o       = buf_q[head_q];
   assign chkpt_head_o       = head_q;
   assign chkpt_tail_o       = tail_q;
   assign chkpt_free_count_o = count_q;
   assign empty_o            = (count_q == '0);
   assign error_o            = error_q;
endmodule
